// File: rtl/charlcd_pkg.sv
// charlcd_pkg: state encoding, HD44780 init table and write-timing helpers
// shared by the character-LCD controller and its timer.
package charlcd_pkg;

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT} state_t;

    localparam int INIT_LEN = 4;
    localparam int IDX_W    = $clog2(INIT_LEN);

    localparam logic [7:0] INIT_FUNC  = 8'h38;
    localparam logic [7:0] INIT_DISP  = 8'h0C;
    localparam logic [7:0] INIT_ENTRY = 8'h06;
    localparam logic [7:0] INIT_CLEAR = 8'h01;

    function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(0) ? INIT_FUNC  :
               idx == IDX_W'(1) ? INIT_DISP  :
               idx == IDX_W'(2) ? INIT_ENTRY : INIT_CLEAR;
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long(input logic rs, input logic [7:0] data);
        return !rs && data[7:2] == 6'd0;
    endfunction

endpackage

// File: rtl/charlcd_timer.sv
// charlcd_timer: shared down-counter; a start loads N and done pulses
// N+1 cycles later, so a state that loads N-1 lasts exactly N cycles.
module charlcd_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] load_i,
    output logic         busy_o,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic         busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            cnt_q  <= load_i;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            cnt_q  <= cnt_q == '0 ? cnt_q : cnt_q - W'(1);
            busy_q <= cnt_q != '0;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && cnt_q == '0;

endmodule

// File: rtl/charlcd_ctrl.sv
// charlcd_ctrl: write-only HD44780 8-bit bus controller; runs the power-up
// wait and init table, then forwards upstream bytes with EN/setup/hold timing.
module charlcd_ctrl
    import charlcd_pkg::*;
#(
    parameter int T_PWRUP = 150000,
    parameter int T_SETUP = 1,
    parameter int T_EN    = 5,
    parameter int T_HOLD  = 1,
    parameter int T_SHORT = 400,
    parameter int T_LONG  = 16400
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic [7:0] LCD_DATA
);

    localparam int TMAX = T_PWRUP > T_LONG ? T_PWRUP : T_LONG;
    localparam int CW   = $clog2(TMAX + 1);

    // PWRUP starts its timer one cycle after release, hence the extra -1.
    localparam logic [CW-1:0] L_PWRUP = CW'(T_PWRUP - 2);
    localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] L_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] L_SHORT = CW'(T_SHORT - 1);
    localparam logic [CW-1:0] L_LONG  = CW'(T_LONG - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             en_q;
    logic             tmr_start, tmr_busy, tmr_done;
    logic [CW-1:0]    tmr_load;

    charlcd_timer #(.W(CW)) u_timer (
        .clk_i  (PCLK),
        .rst_ni (PRESETn),
        .start_i(tmr_start),
        .load_i (tmr_load),
        .busy_o (tmr_busy),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = done_q;
        rs_d      = rs_q;
        data_d    = data_q;
        tmr_start = 1'b0;
        tmr_load  = L_SETUP;
        case (state_q)
            PWRUP: begin
                tmr_start = !tmr_busy;
                tmr_load  = L_PWRUP;
                state_d   = tmr_done ? INIT : PWRUP;
            end
            INIT: begin
                rs_d      = 1'b0;
                data_d    = init_byte(idx_q);
                tmr_start = 1'b1;
                state_d   = SETUP;
            end
            IDLE: begin
                rs_d      = wr_valid ? wr_rs : rs_q;
                data_d    = wr_valid ? wr_data : data_q;
                tmr_start = wr_valid;
                state_d   = wr_valid ? SETUP : IDLE;
            end
            SETUP: begin
                tmr_start = tmr_done;
                tmr_load  = L_EN;
                state_d   = tmr_done ? EN_HI : SETUP;
            end
            EN_HI: begin
                tmr_start = tmr_done;
                tmr_load  = L_HOLD;
                state_d   = tmr_done ? HOLD : EN_HI;
            end
            HOLD: begin
                tmr_start = tmr_done;
                tmr_load  = is_long(rs_q, data_q) ? L_LONG : L_SHORT;
                state_d   = tmr_done ? WAIT : HOLD;
            end
            WAIT: begin
                if (tmr_done) begin
                    if (done_q || idx_q == IDX_W'(INIT_LEN - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = INIT;
                    end
                end
            end
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= PWRUP;
            idx_q   <= '0;
            done_q  <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= state_d == EN_HI;
        end
    end

    assign wr_ready  = state_q == IDLE;
    assign init_done = done_q;
    assign LCD_RS    = rs_q;
    assign LCD_RW    = 1'b0;
    assign LCD_EN    = en_q;
    assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_charlcd_ctrl.sv
// tb_charlcd_ctrl: scoreboard bench; the driver pushes expected EN pulses and
// ready times, a negedge monitor pops and compares as the bus shows them.
module tb_charlcd_ctrl;

    localparam int T_PWRUP = 20;
    localparam int T_SETUP = 1;
    localparam int T_EN    = 2;
    localparam int T_HOLD  = 1;
    localparam int T_SHORT = 4;
    localparam int T_LONG  = 10;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, init_done, LCD_RS, LCD_RW, LCD_EN;
    logic [7:0] LCD_DATA;

    charlcd_ctrl #(
        .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
        .T_HOLD(T_HOLD), .T_SHORT(T_SHORT), .T_LONG(T_LONG)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .wr_valid(wr_valid), .wr_rs(wr_rs),
        .wr_data(wr_data), .wr_ready(wr_ready), .init_done(init_done),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         t;
    } pulse_t;

    pulse_t     en_q[$];
    int         rdy_q[$];
    int         done_exp = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] tab [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int wait_of(input logic rs, input logic [7:0] d);
        return (!rs && d < 8'd4) ? T_LONG : T_SHORT;
    endfunction

    // Init bytes follow one another with the same period as host writes.
    task automatic expect_init(input int rel);
        int t = rel + T_PWRUP + 1 + T_SETUP;
        for (int i = 0; i < 4; i++) begin
            en_q.push_back('{1'b0, tab[i], t});
            if (i < 3) t += T_EN + T_HOLD + wait_of(1'b0, tab[i]) + 1 + T_SETUP;
        end
        done_exp = t + T_EN + T_HOLD + wait_of(1'b0, tab[3]);
        rdy_q.push_back(done_exp);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input bit hold, output int a);
        int n = 0;
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        a        = 0;
        while (!wr_ready && n < 2000) begin
            @(negedge PCLK);
            n++;
        end
        if (!wr_ready) begin
            chk("accept_timeout", 32'(n), 32'd0);
            wr_valid = 1'b0;
        end else begin
            a = cyc + 1;
            chk("accept_after_init", init_done, 1'b1);
            en_q.push_back('{rs, d, a + T_SETUP});
            rdy_q.push_back(a + T_SETUP + T_EN + T_HOLD + wait_of(rs, d));
            @(negedge PCLK);
            if (!hold) wr_valid = 1'b0;
        end
    endtask

    pulse_t     p;
    logic       pen = 1'b0, prdy = 1'b0, pdone = 1'b0;
    logic [8:0] pbus = '0, cur = '0;
    int         rise_t = 0;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            pen   = 1'b0;
            prdy  = 1'b0;
            pdone = 1'b0;
            pbus  = '0;
        end else begin
            if (LCD_EN && !pen) begin
                if (en_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL en_unexpected actual data=%0h required=no pulse at cycle %0d", LCD_DATA, cyc);
                end else begin
                    p = en_q.pop_front();
                    chk("en_data", LCD_DATA, p.d);
                    chk("en_rs", LCD_RS, p.rs);
                    chk("en_time", cyc, p.t);
                    chk("setup_bus", pbus, {LCD_RS, LCD_DATA});
                    chk("lcd_rw", LCD_RW, 1'b0);
                end
                rise_t = cyc;
                cur    = {LCD_RS, LCD_DATA};
            end
            if (!LCD_EN && pen) begin
                chk("en_width", cyc - rise_t, T_EN);
                chk("hold_bus", {LCD_RS, LCD_DATA}, cur);
            end
            if (wr_ready && !prdy) begin
                chk("ready_needs_init", init_done, 1'b1);
                if (rdy_q.size() == 0) chk("ready_unexpected", cyc, 32'd0);
                else chk("ready_time", cyc, rdy_q.pop_front());
            end
            if (init_done && !pdone) chk("init_done_time", cyc, done_exp);
            pen   = LCD_EN;
            prdy  = wr_ready;
            pdone = init_done;
            pbus  = {LCD_RS, LCD_DATA};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, n;
        logic rs;
        logic [7:0] d;
        bit hold;
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h55;
        repeat (3) @(negedge PCLK);
        chk("rst_ready", wr_ready, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_en", LCD_EN, 1'b0);
        chk("rst_rs", LCD_RS, 1'b0);
        chk("rst_rw", LCD_RW, 1'b0);
        chk("rst_data", LCD_DATA, 8'h00);
        PRESETn = 1'b1;
        expect_init(cyc);
        send(1'b1, 8'h55, 1'b0, a);
        send(1'b1, 8'h41, 1'b0, a);
        send(1'b0, 8'h01, 1'b0, a);
        send(1'b0, 8'h80, 1'b0, a);
        send(1'b1, 8'h48, 1'b1, a1);
        send(1'b1, 8'h49, 1'b0, a);
        chk("b2b_gap", a - a1, T_SETUP + T_EN + T_HOLD + T_SHORT + 1);
        for (int i = 0; i < 20; i++) begin
            rs   = 1'($urandom_range(0, 1));
            d    = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 3)) : 8'($urandom);
            hold = 1'($urandom_range(0, 1));
            send(rs, d, hold, a);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge PCLK);
        end
        wr_valid = 1'b0;
        send(1'b1, 8'hA5, 1'b0, a);
        n = 0;
        while (!LCD_EN && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        chk("en_before_abort", LCD_EN, 1'b1);
        #2 PRESETn = 1'b0;
        #1;
        chk("abort_en", LCD_EN, 1'b0);
        chk("abort_data", LCD_DATA, 8'h00);
        chk("abort_rs", LCD_RS, 1'b0);
        chk("abort_ready", wr_ready, 1'b0);
        chk("abort_init_done", init_done, 1'b0);
        en_q.delete();
        rdy_q.delete();
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        expect_init(cyc);
        for (int i = 0; i < 4; i++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, a);
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end
        n = 0;
        while ((en_q.size() != 0 || rdy_q.size() != 0) && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        chk("drain_empty", en_q.size() + rdy_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/charlcd_ctrl.md
CHARLCD_CTRL -- requirements
Module: charlcd_ctrl

Interface
REQ-001 SHALL have parameter T_PWRUP, default 150000, meaning power-up wait in PCLK cycles (15 ms at 10 MHz).
REQ-002 SHALL have parameter T_SETUP, default 1, meaning the number of cycles RS/DATA are stable before LCD_EN rises.
REQ-003 SHALL have parameter T_EN, default 5, meaning the LCD_EN high width in cycles.
REQ-004 SHALL have parameter T_HOLD, default 1, meaning the number of cycles RS/DATA are held after LCD_EN falls.
REQ-005 SHALL have parameter T_SHORT, default 400, meaning the post-write wait in cycles for data bytes and ordinary commands (40 us).
REQ-006 SHALL have parameter T_LONG, default 16400, meaning the post-write wait in cycles for clear and home commands (1.64 ms).
REQ-007 SHALL have port PCLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-008 SHALL have port PRESETn, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port wr_valid, input, 1 bit: the upstream APB register block offers a byte.
REQ-010 SHALL have port wr_rs, input, 1 bit: 0 = command, 1 = display data.
REQ-011 SHALL have port wr_data, input, 8 bits: the byte to write.
REQ-012 SHALL have port wr_ready, output, 1 bit: the controller accepts a byte this cycle.
REQ-013 SHALL have port init_done, output, 1 bit: the power-up init sequence is complete.
REQ-014 SHALL have ports LCD_RS, LCD_RW, LCD_EN, all outputs of 1 bit, and port LCD_DATA, output, 8 bits: the HD44780 8-bit bus.

Function
REQ-015 SHALL implement FSM states PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT.
REQ-016 SHALL stay in PWRUP for T_PWRUP cycles after reset release, then enter INIT.
REQ-017 In INIT, SHALL issue the init table 0x38, 0x0C, 0x06, 0x01 (RS=0) in order, each through SETUP/EN_HI/HOLD/WAIT; the init index SHALL advance after each WAIT.
REQ-018 SHALL set init_done to 1 after the WAIT of the last init byte, enter IDLE, and hold init_done at 1 until reset.
REQ-019 SHALL assert wr_ready only in IDLE; a handshake occurs on the edge where wr_valid and wr_ready are both 1.
REQ-020 On handshake, SHALL capture wr_rs/wr_data into holding registers and move to SETUP; LCD_RS/LCD_DATA SHALL be driven from those registers from the next cycle until HOLD ends.
REQ-021 SHALL spend exactly T_SETUP cycles in SETUP (EN=0), T_EN in EN_HI (EN=1), T_HOLD in HOLD (EN=0), then T_SHORT or T_LONG in WAIT.
REQ-022 SHALL use T_LONG when RS=0 and data[7:2]==0 (clear/home); otherwise T_SHORT.
REQ-023 wr_ready SHALL reassert exactly T_SETUP+T_EN+T_HOLD+T_WAIT+1 cycles after the accepting edge.
REQ-024 SHALL ignore wr_valid in PWRUP/INIT and while busy; no byte is lost or duplicated, because the upstream holds it until the handshake.
REQ-025 SHALL tie LCD_RW to 0 (write-only; no busy-flag read).
REQ-026 SHALL drive LCD_EN only from a register (glitch-free), and SHALL use a single down-counter wide enough for max(T_PWRUP, T_LONG) for all timing.

Reset
REQ-027 On PRESETn=0, SHALL asynchronously force the state to PWRUP, all counters and init index to 0, init_done=0, wr_ready=0, LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_DATA=0x00.
REQ-028 Reset mid-transfer SHALL abort immediately (EN drops the same instant) and the full power-up and init sequence SHALL rerun after release.

Structure
REQ-029 Package charlcd_pkg SHALL hold the state encoding, the init table constants (0x38, 0x0C, 0x06, 0x01), and the init table length 4.
REQ-030 Sub-module charlcd_timer (load value, start, done pulse) SHALL implement the shared down-counter; the FSM SHALL remain in charlcd_ctrl.

Verification (params T_PWRUP=20, T_SETUP=1, T_EN=2, T_HOLD=1, T_SHORT=4, T_LONG=10)
REQ-031 Reset release -> first LCD_EN rise 21 cycles later with DATA=0x38, RS=0; then 0x0C, 0x06, 0x01; init_done=1 after the 0x01 long wait.
REQ-032 After init, write RS=1 data 0x41 -> EN high 2 cycles starting 2 cycles after accept, DATA=0x41 and RS=1 stable from setup through hold; wr_ready returns after 9 cycles.
REQ-033 Write RS=0 data 0x01 -> WAIT lasts 10 cycles; wr_ready returns after 15 cycles. Write RS=0 data 0x80 -> wr_ready returns after 9 cycles.
REQ-034 wr_valid held at 1 from reset release with data 0x55 -> no handshake before init_done; exactly one 0x55 EN pulse afterwards.
REQ-035 PRESETn pulsed low during EN_HI -> LCD_EN=0 and all outputs 0 immediately; after release, init restarts at 0x38 after 20 cycles.
REQ-036 Back-to-back writes 0x48, 0x49 with wr_valid held high -> two EN pulses 9 cycles apart with correct data; LCD_RW=0 throughout.
